// File: rtl/md_ctrl.sv
// Multiply/divide controller beside the E-stage ALU: owns HI/LO, sequences multi-cycle
// MULT/DIV with a fixed busy window, and requests a D-stage stall for HI/LO users.
module md_ctrl #(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  E_md_op,
    input  logic [31:0] E_in1,
    input  logic [31:0] E_in2,
    input  logic        D_md_use,
    output logic        md_start,
    output logic        md_busy,
    output logic        md_done,
    output logic        md_stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    if (MULT_CYC < 1 || MULT_CYC > 15) begin : g_bad_mult_cyc
        $error("MULT_CYC must be in 1..15");
    end
    if (DIV_CYC < 1 || DIV_CYC > 15) begin : g_bad_div_cyc
        $error("DIV_CYC must be in 1..15");
    end

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYC);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYC);

    logic [0:0]  state_q;
    logic [3:0]  cnt_q;
    logic [31:0] hi_q, lo_q;
    logic [31:0] pend_hi_q, pend_lo_q;
    logic        done_q;

    logic [63:0] smul, umul;
    logic [31:0] a_mag, b_mag, q_mag, r_mag;
    logic [31:0] uquo, urem;
    logic [31:0] res_hi, res_lo;

    assign smul = $signed({{32{E_in1[31]}}, E_in1}) * $signed({{32{E_in2[31]}}, E_in2});
    assign umul = {32'b0, E_in1} * {32'b0, E_in2};

    // Signed division is done on magnitudes so 0x80000000 / -1 wraps to 0x80000000.
    assign a_mag = E_in1[31] ? (32'd0 - E_in1) : E_in1;
    assign b_mag = E_in2[31] ? (32'd0 - E_in2) : E_in2;

    always_comb begin
        q_mag = 32'd0;
        r_mag = 32'd0;
        uquo  = 32'd0;
        urem  = 32'd0;
        if (E_in2 != 32'd0) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
            uquo  = E_in1 / E_in2;
            urem  = E_in1 % E_in2;
        end
    end

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        case (E_md_op)
            OP_MULT:  {res_hi, res_lo} = smul;
            OP_MULTU: {res_hi, res_lo} = umul;
            OP_DIV: begin
                if (E_in2 == 32'd0) begin
                    res_lo = 32'hFFFF_FFFF;
                    res_hi = E_in1;
                end else begin
                    res_lo = (E_in1[31] ^ E_in2[31]) ? (32'd0 - q_mag) : q_mag;
                    res_hi = E_in1[31] ? (32'd0 - r_mag) : r_mag;
                end
            end
            OP_DIVU: begin
                if (E_in2 == 32'd0) begin
                    res_lo = 32'hFFFF_FFFF;
                    res_hi = E_in1;
                end else begin
                    res_lo = uquo;
                    res_hi = urem;
                end
            end
            default: ;
        endcase
    end

    assign md_start = (E_md_op >= OP_MULT) && (E_md_op <= OP_DIVU) && (state_q == ST_IDLE);
    assign md_busy  = (state_q == ST_RUN);
    assign md_done  = done_q;
    assign md_stall = D_md_use & (md_start | md_busy);
    assign HI       = hi_q;
    assign LO       = lo_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == ST_IDLE) begin
                if (md_start) begin
                    pend_hi_q <= res_hi;
                    pend_lo_q <= res_lo;
                    cnt_q     <= (E_md_op <= OP_MULTU) ? MULT_CNT : DIV_CNT;
                    state_q   <= ST_RUN;
                end else if (E_md_op == OP_MTHI) begin
                    hi_q <= E_in1;
                end else if (E_md_op == OP_MTLO) begin
                    lo_q <= E_in1;
                end
            end else begin
                // Any op presented while running is ignored; the stall keeps it from happening.
                if (cnt_q == 4'd1) begin
                    hi_q    <= pend_hi_q;
                    lo_q    <= pend_lo_q;
                    done_q  <= 1'b1;
                    cnt_q   <= 4'd0;
                    state_q <= ST_IDLE;
                end else begin
                    cnt_q <= cnt_q - 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_md_ctrl.sv
// Bench for md_ctrl: directed scenarios plus random ops, checked every cycle against a
// transaction-level model (64-bit arithmetic and a remaining-busy-cycles counter).
module tb_md_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk;
    logic        rst_n;
    logic [2:0]  E_md_op;
    logic [31:0] E_in1, E_in2;
    logic        D_md_use;
    logic        md_start, md_busy, md_done, md_stall;
    logic [31:0] HI, LO;

    md_ctrl #(.MULT_CYC(MULT_N), .DIV_CYC(DIV_N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .E_md_op  (E_md_op),
        .E_in1    (E_in1),
        .E_in2    (E_in2),
        .D_md_use (D_md_use),
        .md_start (md_start),
        .md_busy  (md_busy),
        .md_done  (md_done),
        .md_stall (md_stall),
        .HI       (HI),
        .LO       (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int          busy_left = 0;
    logic [31:0] m_hi = 0, m_lo = 0, m_phi = 0, m_plo = 0;
    logic        m_done = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void ref_calc(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b, output logic [31:0] h,
                                     output logic [31:0] l);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        h = 0;
        l = 0;
        case (op)
            3'd1: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
            3'd2: begin p = ua * ub; h = p[63:32]; l = p[31:0]; end
            3'd3, 3'd4: begin
                if (b == 0) begin
                    l = 32'hFFFF_FFFF;
                    h = a;
                end else if (op == 3'd3) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    p = sq; l = p[31:0];
                    p = sr; h = p[31:0];
                end else begin
                    p = ua / ub; l = p[31:0];
                    p = ua % ub; h = p[31:0];
                end
            end
            default: ;
        endcase
    endfunction

    // One clock: called just after a negedge, returns just after the next negedge.
    task automatic step(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic use_d);
        logic exp_start;
        check("busy", {31'b0, md_busy}, {31'b0, busy_left > 0});
        check("done", {31'b0, md_done}, {31'b0, m_done});
        check("hi", HI, m_hi);
        check("lo", LO, m_lo);
        E_md_op  = op;
        E_in1    = a;
        E_in2    = b;
        D_md_use = use_d;
        #1;
        exp_start = (op >= 1 && op <= 4 && busy_left == 0);
        check("start", {31'b0, md_start}, {31'b0, exp_start});
        check("stall", {31'b0, md_stall}, {31'b0, use_d & (exp_start | (busy_left > 0))});
        @(posedge clk);
        m_done = 0;
        if (busy_left > 0) begin
            if (busy_left == 1) begin
                m_hi = m_phi;
                m_lo = m_plo;
                m_done = 1;
            end
            busy_left--;
        end else if (exp_start) begin
            ref_calc(op, a, b, m_phi, m_plo);
            busy_left = (op <= 2) ? MULT_N : DIV_N;
        end else if (op == 3'd5) begin
            m_hi = a;
        end else if (op == 3'd6) begin
            m_lo = a;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic use_d);
        for (int i = 0; i < n; i++) step(3'd0, $urandom, $urandom, use_d);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        busy_left = 0;
        m_hi = 0; m_lo = 0; m_done = 0;
        check("rst_busy", {31'b0, md_busy}, 32'd0);
        check("rst_done", {31'b0, md_done}, 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst_n = 1'b0; E_md_op = 0; E_in1 = 0; E_in2 = 0; D_md_use = 0;
        @(negedge clk);
        do_reset();

        // Signed multiply
        step(3'd1, -32'sd3, 32'd7, 1'b0);
        idle(MULT_N + 1, 1'b0);
        check("mult_hi", HI, 32'hFFFF_FFFF);
        check("mult_lo", LO, 32'hFFFF_FFEB);

        // Unsigned and signed divide
        step(3'd4, 32'd100, 32'd7, 1'b0);
        idle(DIV_N, 1'b0);
        check("divu_lo", LO, 32'd14);
        check("divu_hi", HI, 32'd2);
        step(3'd3, -32'sd7, 32'd2, 1'b0);
        idle(DIV_N, 1'b0);
        check("div_lo", LO, 32'hFFFF_FFFD);
        check("div_hi", HI, 32'hFFFF_FFFF);

        // Stall held through start and busy cycles
        step(3'd1, 32'd9, 32'd9, 1'b1);
        idle(MULT_N + 2, 1'b1);

        // Divide by zero and signed overflow
        step(3'd3, 32'h1234, 32'd0, 1'b0);
        idle(DIV_N, 1'b0);
        check("div0_lo", LO, 32'hFFFF_FFFF);
        check("div0_hi", HI, 32'h0000_1234);
        step(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        idle(DIV_N, 1'b0);
        check("ovf_lo", LO, 32'h8000_0000);
        check("ovf_hi", HI, 32'd0);

        // MTHI / MTLO
        step(3'd5, 32'hA5A5_A5A5, 32'd0, 1'b1);
        step(3'd6, 32'h5A5A_5A5A, 32'd0, 1'b1);
        idle(1, 1'b0);
        check("mthi", HI, 32'hA5A5_A5A5);
        check("mtlo", LO, 32'h5A5A_5A5A);

        // Reset in the middle of a multiply, then MULTU
        step(3'd1, 32'd5, 32'd6, 1'b0);
        idle(2, 1'b0);
        do_reset();
        step(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
        idle(MULT_N, 1'b0);
        check("multu_hi", HI, 32'd1);
        check("multu_lo", LO, 32'hFFFF_FFFE);

        // Random traffic, including ops presented while busy
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else if (busy_left > 0 && $urandom_range(0, 3) != 0) begin
                step(3'd0, $urandom, $urandom, 1'($urandom));
            end else begin
                step(3'($urandom_range(0, 7)), pick_val(), pick_val(), 1'($urandom));
            end
        end
        idle(DIV_N + 1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
